// File: rtl/nmi_mbox_pkg.sv
// Shared definitions for the NMI mailbox: register indices, STAT/CTRL bit
// positions, handshake states and the block's base address.
package nmi_mbox_pkg;

    // Base address of the mailbox window in the native peripheral map.
    localparam logic [31:0] NMI_MBOX_BASE = 32'h0000_FF40;

    typedef enum logic [1:0] {
        MBOX_DATA   = 2'd0,
        MBOX_STAT   = 2'd1,
        MBOX_CTRL   = 2'd2,
        MBOX_THRESH = 2'd3
    } mbox_reg_e;

    localparam int STAT_EMPTY  = 8;
    localparam int STAT_FULL   = 9;
    localparam int STAT_OVF    = 10;
    localparam int STAT_UDF    = 11;

    localparam int CTRL_IRQ_EN = 0;
    localparam int CTRL_FLUSH  = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } mbox_state_e;

endpackage

// File: rtl/nmi_mbox_if.sv
// Native-memory-interface request/response bundle; the initiator drives the
// request side, the mailbox answers with a one-cycle ready strobe.
interface nmi_mbox_if;
    logic        nmi_valid_i;
    logic [31:0] nmi_addr_i;
    logic [31:0] nmi_wdata_i;
    logic [3:0]  nmi_wstrb_i;
    logic        nmi_ready_o;
    logic [31:0] nmi_rdata_o;

    modport master (
        output nmi_valid_i, nmi_addr_i, nmi_wdata_i, nmi_wstrb_i,
        input  nmi_ready_o, nmi_rdata_o
    );

    modport slave (
        input  nmi_valid_i, nmi_addr_i, nmi_wdata_i, nmi_wstrb_i,
        output nmi_ready_o, nmi_rdata_o
    );
endinterface

// File: rtl/nmi_mbox_fifo.sv
// Synchronous word FIFO with a separate level counter; push when full and
// pop when empty are ignored, flush only rewinds pointers and level.
module mbox_fifo #(
    parameter int  DEPTH = 8,
    localparam int LVL_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [31:0]      wdata_i,
    output logic [LVL_W-1:0] level_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [31:0]      head_o
);

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;

    assign full_o  = (level == LVL_W'(DEPTH));
    assign empty_o = (level == '0);
    assign level_o = level;
    assign head_o  = mem[rd_ptr];

    // NOTE: storage is deliberately left out of reset; pointers and level alone
    // define which entries are meaningful, so resetting the array buys nothing.
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem[wr_ptr] <= wdata_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (push_i && !full_o) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            level  <= level + LVL_W'(1);
        end else if (pop_i && !empty_o) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            level  <= level - LVL_W'(1);
        end
    end

endmodule

// File: rtl/nmi_mbox.sv
// Software mailbox on the native peripheral bus: two-state valid/ready
// responder, register decode over a word FIFO, and a threshold level interrupt.
module nmi_mbox
    import nmi_mbox_pkg::*;
#(
    parameter int  DEPTH = 8,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    nmi_mbox_if.slave bus,
    output logic      irq_o
);

    mbox_state_e      state;
    logic             ovf;
    logic             udf;
    logic             irq_en;
    logic [LVL_W-1:0] thresh;

    logic [LVL_W-1:0] level;
    logic             full;
    logic             empty;
    logic [31:0]      head;

    logic             access;
    logic             is_write;
    mbox_reg_e        reg_idx;
    logic             push;
    logic             pop;
    logic             flush;
    logic [LVL_W-1:0] thresh_wr;
    logic             irq_d;
    logic [31:0]      stat_word;
    logic [31:0]      read_data;
    logic             unused_addr;

    assign access   = (state == ST_IDLE) && bus.nmi_valid_i;
    assign is_write = |bus.nmi_wstrb_i;
    assign reg_idx  = mbox_reg_e'(bus.nmi_addr_i[3:2]);
    assign push     = access && is_write  && (reg_idx == MBOX_DATA);
    assign pop      = access && !is_write && (reg_idx == MBOX_DATA);
    assign flush    = access && is_write  && (reg_idx == MBOX_CTRL)
                      && bus.nmi_wstrb_i[0] && bus.nmi_wdata_i[CTRL_FLUSH];

    assign thresh_wr = (bus.nmi_wdata_i[LVL_W-1:0] > LVL_W'(DEPTH))
                       ? LVL_W'(DEPTH) : bus.nmi_wdata_i[LVL_W-1:0];
    assign irq_d     = irq_en && (thresh != '0) && (level >= thresh);

    assign unused_addr = ^{bus.nmi_addr_i[31:4], bus.nmi_addr_i[1:0]};

    mbox_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (bus.nmi_wdata_i),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        stat_word                 = '0;
        stat_word[LVL_W-1:0]      = level;
        stat_word[STAT_EMPTY]     = empty;
        stat_word[STAT_FULL]      = full;
        stat_word[STAT_OVF]       = ovf;
        stat_word[STAT_UDF]       = udf;

        read_data = '0;
        unique case (reg_idx)
            MBOX_DATA:   read_data = empty ? '0 : head;
            MBOX_STAT:   read_data = stat_word;
            MBOX_CTRL:   read_data = 32'(irq_en);
            MBOX_THRESH: read_data = 32'(thresh);
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= ST_IDLE;
            bus.nmi_ready_o <= 1'b0;
            bus.nmi_rdata_o <= '0;
            ovf             <= 1'b0;
            udf             <= 1'b0;
            irq_en          <= 1'b0;
            thresh          <= '0;
            irq_o           <= 1'b0;
        end else begin
            irq_o <= irq_d;
            unique case (state)
                ST_IDLE: begin
                    bus.nmi_ready_o <= 1'b0;
                    if (bus.nmi_valid_i) begin
                        state           <= ST_RESP;
                        bus.nmi_ready_o <= 1'b1;
                        bus.nmi_rdata_o <= is_write ? '0 : read_data;

                        if (push && full) ovf <= 1'b1;
                        if (pop && empty) udf <= 1'b1;

                        if (is_write) begin
                            unique case (reg_idx)
                                MBOX_STAT: if (bus.nmi_wstrb_i[1]) begin
                                    if (bus.nmi_wdata_i[STAT_OVF]) ovf <= 1'b0;
                                    if (bus.nmi_wdata_i[STAT_UDF]) udf <= 1'b0;
                                end
                                MBOX_CTRL: if (bus.nmi_wstrb_i[0]) begin
                                    irq_en <= bus.nmi_wdata_i[CTRL_IRQ_EN];
                                end
                                MBOX_THRESH: if (bus.nmi_wstrb_i[0]) begin
                                    thresh <= thresh_wr;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                // Valid is not looked at here, so a held request runs only once.
                ST_RESP: begin
                    state           <= ST_IDLE;
                    bus.nmi_ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nmi_mbox.sv
// Self-checking bench for nmi_mbox: directed steps from the test plan, then
// random traffic compared against a queue-based model of the mailbox.
module tb_nmi_mbox;

    localparam int DEPTH = 8;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic clk_i = 1'b0;
    logic rst_i;
    logic irq_o;

    nmi_mbox_if bus ();

    nmi_mbox #(.DEPTH(DEPTH)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus),
        .irq_o (irq_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [31:0] q [$];
    bit          m_ovf;
    bit          m_udf;
    bit          m_en;
    int          m_thr;

    task automatic check(input string tag, input string what,
                         input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s/%s: got %h expected %h", tag, what, obs, exp);
        end
    endtask

    function automatic void m_reset();
        q.delete();
        m_ovf = 0;
        m_udf = 0;
        m_en  = 0;
        m_thr = 0;
    endfunction

    function automatic logic m_irq();
        return m_en && (m_thr != 0) && (q.size() >= m_thr);
    endfunction

    function automatic logic [31:0] m_stat();
        int lvl = q.size();
        return 32'(lvl) | (lvl == 0 ? 32'h100 : 32'h0) | (lvl == DEPTH ? 32'h200 : 32'h0)
             | (m_ovf ? 32'h400 : 32'h0) | (m_udf ? 32'h800 : 32'h0);
    endfunction

    // Applies one access to the model; returns the expected read data.
    function automatic logic [31:0] m_access(input logic [1:0] idx, input logic [31:0] wd,
                                             input logic [3:0] ws);
        bit wr = (ws != 4'h0);
        int t;
        case (idx)
            2'd0: begin
                if (wr) begin
                    if (q.size() < DEPTH) q.push_back(wd);
                    else m_ovf = 1;
                end else if (q.size() == 0) begin
                    m_udf = 1;
                end else begin
                    return q.pop_front();
                end
            end
            2'd1: begin
                if (!wr) return m_stat();
                if (ws[1] && wd[10]) m_ovf = 0;
                if (ws[1] && wd[11]) m_udf = 0;
            end
            2'd2: begin
                if (!wr) return 32'(m_en);
                if (ws[0]) begin
                    m_en = wd[0];
                    if (wd[1]) q.delete();
                end
            end
            default: begin
                if (!wr) return 32'(m_thr);
                if (ws[0]) begin
                    t = int'(wd[LVL_W-1:0]);
                    m_thr = (t > DEPTH) ? DEPTH : t;
                end
            end
        endcase
        return 32'h0;
    endfunction

    task automatic drive(input logic [1:0] idx, input logic [31:0] wd, input logic [3:0] ws);
        bus.nmi_valid_i = 1'b1;
        bus.nmi_addr_i  = {28'h0, idx, 2'b00};
        bus.nmi_wdata_i = wd;
        bus.nmi_wstrb_i = ws;
    endtask

    // One complete transaction, checking latency, single-cycle ready, read
    // data and the one-cycle lag of irq_o behind the state change.
    task automatic access(input string tag, input logic [1:0] idx, input logic [31:0] wd,
                          input logic [3:0] ws, output logic [31:0] rd);
        logic        pre_irq;
        logic        post_irq;
        logic [31:0] exp;
        pre_irq  = m_irq();
        exp      = m_access(idx, wd, ws);
        post_irq = m_irq();
        @(negedge clk_i);
        drive(idx, wd, ws);
        @(posedge clk_i);
        #1;
        check(tag, "ready", 32'(bus.nmi_ready_o), 32'd1);
        check(tag, "irq_lag", 32'(irq_o), 32'(pre_irq));
        rd = bus.nmi_rdata_o;
        if (ws == 4'h0) check(tag, "rdata", rd, exp);
        bus.nmi_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        check(tag, "ready_low", 32'(bus.nmi_ready_o), 32'd0);
        check(tag, "irq", 32'(irq_o), 32'(post_irq));
    endtask

    // Reset is pulsed while the DUT is in RESP; valid stays held throughout.
    task automatic reset_in_resp(input string tag, input logic [1:0] idx,
                                 input logic [31:0] wd, input logic [3:0] ws);
        logic [31:0] exp;
        exp = m_access(idx, wd, ws);
        @(negedge clk_i);
        drive(idx, wd, ws);
        @(posedge clk_i);
        #1;
        check(tag, "ready_pre", 32'(bus.nmi_ready_o), 32'd1);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check(tag, "ready_rst", 32'(bus.nmi_ready_o), 32'd0);
        check(tag, "rdata_rst", bus.nmi_rdata_o, 32'd0);
        check(tag, "irq_rst", 32'(irq_o), 32'd0);
        rst_i = 1'b0;
        m_reset();
        exp = m_access(idx, wd, ws);
        @(posedge clk_i);
        #1;
        check(tag, "ready_post", 32'(bus.nmi_ready_o), 32'd1);
        if (ws == 4'h0) check(tag, "rdata_post", bus.nmi_rdata_o, exp);
        bus.nmi_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        check(tag, "ready_once", 32'(bus.nmi_ready_o), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  idx;
        logic [31:0] wd;
        logic [3:0]  ws;

        rst_i           = 1'b1;
        bus.nmi_valid_i = 1'b0;
        bus.nmi_addr_i  = '0;
        bus.nmi_wdata_i = '0;
        bus.nmi_wstrb_i = '0;
        m_reset();
        repeat (3) @(posedge clk_i);
        #1;
        check("reset", "ready", 32'(bus.nmi_ready_o), 32'd0);
        check("reset", "rdata", bus.nmi_rdata_o, 32'd0);
        check("reset", "irq", 32'(irq_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        access("stat_empty", 2'd1, 0, 4'h0, rd);
        check("stat_empty", "const", rd, 32'h100);

        access("push11", 2'd0, 32'h11, 4'hF, rd);
        access("push22", 2'd0, 32'h22, 4'h1, rd);
        access("push33", 2'd0, 32'h33, 4'h8, rd);
        access("stat3", 2'd1, 0, 4'h0, rd);
        check("stat3", "const", rd, 32'h003);
        access("pop11", 2'd0, 0, 4'h0, rd);
        check("pop11", "const", rd, 32'h11);
        access("pop22", 2'd0, 0, 4'h0, rd);
        access("pop33", 2'd0, 0, 4'h0, rd);
        check("pop33", "const", rd, 32'h33);
        access("stat0", 2'd1, 0, 4'h0, rd);

        for (int i = 0; i < DEPTH; i++) access("fill", 2'd0, $urandom, 4'hF, rd);
        access("push_full", 2'd0, 32'hDEAD, 4'hF, rd);
        access("stat_full", 2'd1, 0, 4'h0, rd);
        check("stat_full", "const", rd, 32'h608);
        access("clr_ovf", 2'd1, 32'h400, 4'h2, rd);
        access("stat_clr", 2'd1, 0, 4'h0, rd);
        check("stat_clr", "const", rd, 32'h208);
        for (int i = 0; i < DEPTH; i++) access("drain", 2'd0, 0, 4'h0, rd);
        for (int i = 0; i < DEPTH; i++) begin
            access("wrap_push", 2'd0, $urandom, 4'hF, rd);
            access("wrap_pop", 2'd0, 0, 4'h0, rd);
        end

        access("pop_empty", 2'd0, 0, 4'h0, rd);
        check("pop_empty", "const", rd, 32'h0);
        access("stat_udf", 2'd1, 0, 4'h0, rd);
        check("stat_udf", "const", rd, 32'h900);
        access("clr_udf", 2'd1, 32'h800, 4'h2, rd);

        access("thresh2", 2'd3, 32'd2, 4'h1, rd);
        access("irq_en", 2'd2, 32'd1, 4'h1, rd);
        access("irq_push1", 2'd0, 32'hA1, 4'hF, rd);
        access("irq_push2", 2'd0, 32'hA2, 4'hF, rd);
        check("irq_push2", "const", 32'(irq_o), 32'd1);
        access("irq_pop", 2'd0, 0, 4'h0, rd);
        check("irq_pop", "const", 32'(irq_o), 32'd0);
        access("flush", 2'd2, 32'h3, 4'h1, rd);
        access("stat_flush", 2'd1, 0, 4'h0, rd);
        access("thresh_sat", 2'd3, 32'd15, 4'h1, rd);
        access("thresh_rd", 2'd3, 0, 4'h0, rd);
        check("thresh_rd", "const", rd, 32'd8);

        for (int i = 0; i < 4; i++) access("pre_rst", 2'd0, $urandom, 4'hF, rd);
        reset_in_resp("rst_stat", 2'd1, 0, 4'h0);
        for (int i = 0; i < 4; i++) access("pre_rst2", 2'd0, $urandom, 4'hF, rd);
        reset_in_resp("rst_push", 2'd0, 32'hABCD, 4'h4);
        access("stat_after", 2'd1, 0, 4'h0, rd);
        access("pop_after", 2'd0, 0, 4'h0, rd);

        for (int i = 0; i < 300; i++) begin
            idx = 2'($urandom_range(0, 3));
            ws  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            wd  = $urandom;
            if (idx == 2'd2) wd = {30'h0, ($urandom_range(0, 7) == 0), wd[0]};
            if (idx == 2'd3) wd = 32'($urandom_range(0, 15));
            access("rand", idx, wd, ws, rd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
